stopwatch_bcd: RTL

Stopwatch core that consumes the 1/100 s tick from the clock-divider stage and keeps a four-digit BCD elapsed time (SS.hh, 00.00 to 59.99). It runs a start/stop/clear state machine, a lap-freeze display latch and a sticky overflow flag. Its digit outputs drive the seven-segment decode stage directly.

---
 rtl/stopwatch_bcd_if.sv | 39 +++
 rtl/stopwatch_bcd.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_if.sv
// rtl/stopwatch_bcd_if.sv - control/status bundle between the stopwatch core and its neighbours
//
// Signals:
//   hundrethSec  1/100 s tick from the divider stage (one clock wide)
//   start_stop   synchronized, debounced run/stop level
//   clr          synchronized clear level
//   lap          synchronized lap level
//   dig_hund     displayed hundredths digit (BCD)
//   dig_tenth    displayed tenths digit (BCD)
//   dig_sec1     displayed seconds-ones digit (BCD)
//   dig_sec10    displayed seconds-tens digit (BCD)
//   running      state is RUN
//   lap_hold     display frozen by lap
//   ovf          sticky wrap flag
// Modports: master drives the controls and reads the display; slave is the core.

interface stopwatch_bcd_if;
    logic       hundrethSec;
    logic       start_stop;
    logic       clr;
    logic       lap;
    logic [3:0] dig_hund;
    logic [3:0] dig_tenth;
    logic [3:0] dig_sec1;
    logic [3:0] dig_sec10;
    logic       running;
    logic       lap_hold;
    logic       ovf;

    modport master (
        output hundrethSec, start_stop, clr, lap,
        input  dig_hund, dig_tenth, dig_sec1, dig_sec10, running, lap_hold, ovf
    );

    modport slave (
        input  hundrethSec, start_stop, clr, lap,
        output dig_hund, dig_tenth, dig_sec1, dig_sec10, running, lap_hold, ovf
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - BCD stopwatch core: start/stop/clear FSM, lap freeze, sticky overflow
//
// Parameters:
//   MAX_TENS_SEC  highest value of the seconds-tens digit before wrapping to 00.00
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  synchronous active-high reset
//   sw   stopwatch_bcd_if.slave (tick/level inputs, digit and status outputs)

module stopwatch_bcd #(
    parameter int unsigned MAX_TENS_SEC = 5
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_bcd_if.slave   sw
);

    localparam logic [3:0] TENS_MAX = 4'(MAX_TENS_SEC);
    localparam logic [3:0] NINE     = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Input level registers and registered edge pulses. The pulse register
    // gives the one-cycle edge-detect delay seen on running/lap_hold.
    logic        ss_q, clr_q, lap_q;
    logic        ss_edge_q, clr_edge_q, lap_edge_q;

    // Live count and display latch, packed {sec10, sec1, tenth, hund}.
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] cnt_inc;
    logic        cnt_wrap;

    logic        lap_hold_q, lap_hold_d;
    logic        ovf_q, ovf_d;
    logic        running_q;
    logic        tick_en;

    // Tick is qualified by the state before any transition this cycle.
    assign tick_en = sw.hundrethSec && (state_q == S_RUN);

    // BCD increment with ripple carry through all four digits.
    always_comb begin
        cnt_inc  = cnt_q;
        cnt_wrap = 1'b0;
        if (cnt_q[3:0] != NINE) begin
            cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
        end else begin
            cnt_inc[3:0] = 4'd0;
            if (cnt_q[7:4] != NINE) begin
                cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
            end else begin
                cnt_inc[7:4] = 4'd0;
                if (cnt_q[11:8] != NINE) begin
                    cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
                end else begin
                    cnt_inc[11:8] = 4'd0;
                    if (cnt_q[15:12] != TENS_MAX) begin
                        cnt_inc[15:12] = cnt_q[15:12] + 4'd1;
                    end else begin
                        cnt_inc[15:12] = 4'd0;
                        cnt_wrap       = 1'b1;
                    end
                end
            end
        end
    end

    // Next-state for FSM, count, flags and display.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        lap_hold_d = lap_hold_q;
        disp_d     = disp_q;

        if (tick_en) begin
            cnt_d = cnt_inc;
            if (cnt_wrap) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (ss_edge_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ss_edge_q) begin
                    state_d    = S_STOP;
                    lap_hold_d = 1'b0;
                end else if (lap_edge_q) begin
                    if (!lap_hold_q) begin
                        // Freeze the value from before any same-cycle tick.
                        lap_hold_d = 1'b1;
                        disp_d     = cnt_q;
                    end else begin
                        lap_hold_d = 1'b0;
                    end
                end
            end
            S_STOP: begin
                // start_stop beats clr when both edges land together.
                if (ss_edge_q) begin
                    state_d = S_RUN;
                end else if (clr_edge_q) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    lap_hold_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Unfrozen display follows the live count in the same cycle.
        if (!lap_hold_d) begin
            disp_d = cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ss_q       <= 1'b0;
            clr_q      <= 1'b0;
            lap_q      <= 1'b0;
            ss_edge_q  <= 1'b0;
            clr_edge_q <= 1'b0;
            lap_edge_q <= 1'b0;
            cnt_q      <= '0;
            disp_q     <= '0;
            lap_hold_q <= 1'b0;
            ovf_q      <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            ss_q       <= sw.start_stop;
            clr_q      <= sw.clr;
            lap_q      <= sw.lap;
            ss_edge_q  <= sw.start_stop & ~ss_q;
            clr_edge_q <= sw.clr & ~clr_q;
            lap_edge_q <= sw.lap & ~lap_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            lap_hold_q <= lap_hold_d;
            ovf_q      <= ovf_d;
            running_q  <= (state_d == S_RUN);
        end
    end

    assign sw.dig_hund  = disp_q[3:0];
    assign sw.dig_tenth = disp_q[7:4];
    assign sw.dig_sec1  = disp_q[11:8];
    assign sw.dig_sec10 = disp_q[15:12];
    assign sw.running   = running_q;
    assign sw.lap_hold  = lap_hold_q;
    assign sw.ovf       = ovf_q;

endmodule
